// File: rtl/sw_cond.sv
// Push-button conditioner: synchronizes, debounces and edge-detects three
// active-low buttons, with hold-to-repeat on the increment channel.
module sw_cond #(
    parameter int unsigned DEB_CNT  = 500000,
    parameter int unsigned HOLD_CNT = 25000000,
    parameter int unsigned REP_CNT  = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_sw,
    input  logic       i_rep_en,
    output logic [2:0] o_press,
    output logic [2:0] o_level
);

    localparam int unsigned NCH   = 3;
    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CNT - 1);

    typedef enum logic [1:0] {IDLE, DB_P, PRESSED, DB_R} state_t;

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] fsm_press;
    logic [NCH-1:0] level_d;
    logic           ch2_pressed;

    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] rep_cnt_d;
    logic             rep_phase_q;
    logic             rep_phase_d;
    logic             rep_pulse_c;

    // Two-flop synchronizer; released (1) is the reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= i_sw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press_c;
        logic             pressed;

        assign pressed = ~sync2[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_c = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_d = DB_P;
                        cnt_d   = '0;
                    end
                end
                DB_P: begin
                    if (!pressed) begin
                        state_d = IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = PRESSED;
                        press_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state_d = DB_R;
                        cnt_d   = '0;
                    end
                end
                DB_R: begin
                    if (pressed) begin
                        state_d = PRESSED;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign fsm_press[i] = press_c;
        assign level_d[i]   = (state_d == PRESSED) || (state_d == DB_R);

        if (i == 2) begin : g_rep
            assign ch2_pressed = (state_q == PRESSED);
        end
    end

    // Hold-to-repeat: first pulse after HOLD_CNT, then every REP_CNT.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_pulse_c = 1'b0;
        if (!ch2_pressed || !i_rep_en) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (!rep_phase_q && rep_cnt_q == HOLD_LAST) begin
            rep_pulse_c = 1'b1;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
        end else if (rep_phase_q && rep_cnt_q == REP_LAST) begin
            rep_pulse_c = 1'b1;
            rep_cnt_d   = '0;
        end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_press <= '0;
            o_level <= '0;
        end else begin
            o_press <= fsm_press | {rep_pulse_c, 2'b00};
            o_level <= level_d;
        end
    end

endmodule

// File: tb/tb_sw_cond.sv
// Randomized and directed bench for sw_cond against a run-length reference model.
module tb_sw_cond;

    localparam int unsigned DEB_CNT  = 4;
    localparam int unsigned HOLD_CNT = 20;
    localparam int unsigned REP_CNT  = 5;

    logic       clk;
    logic       rst;
    logic [2:0] i_sw;
    logic       i_rep_en;
    logic [2:0] o_press;
    logic [2:0] o_level;

    int n_checks = 0;
    int n_errors = 0;
    int p2_cnt   = 0;
    int p7_cnt   = 0;

    // Reference model state: raw-sample delay line, debounced level,
    // length of the current run disagreeing with the level, hold time.
    bit          d1 [3];
    bit          d2 [3];
    bit          lvl[3];
    int unsigned run[3];
    int unsigned held;

    sw_cond #(
        .DEB_CNT (DEB_CNT),
        .HOLD_CNT(HOLD_CNT),
        .REP_CNT (REP_CNT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_sw    (i_sw),
        .i_rep_en(i_rep_en),
        .o_press (o_press),
        .o_level (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // A level flips once DEB_CNT+1 consecutive edges disagree with it.
    task automatic model_edge(input bit r, input logic [2:0] sw, input bit ren,
                              output logic [2:0] ep, output logic [2:0] el);
        bit p;
        ep = '0;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                d1[i] = 1'b1; d2[i] = 1'b1; lvl[i] = 1'b0; run[i] = 0;
            end
            held = 0;
        end else begin
            if (ren && lvl[2] && run[2] == 0) begin
                held++;
                if (held == HOLD_CNT || (held > HOLD_CNT && (held - HOLD_CNT) % REP_CNT == 0))
                    ep[2] = 1'b1;
            end else begin
                held = 0;
            end
            for (int i = 0; i < 3; i++) begin
                p = !d2[i];
                if (p != lvl[i]) begin
                    run[i]++;
                    if (run[i] == DEB_CNT + 1) begin
                        lvl[i] = p;
                        run[i] = 0;
                        if (p) ep[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
                d2[i] = d1[i];
                d1[i] = sw[i];
            end
        end
        for (int i = 0; i < 3; i++) el[i] = lvl[i];
    endtask

    task automatic step(input bit r, input logic [2:0] sw, input bit ren);
        logic [2:0] ep;
        logic [2:0] el;
        @(negedge clk);
        rst = r; i_sw = sw; i_rep_en = ren;
        @(posedge clk);
        model_edge(r, sw, ren, ep, el);
        #1;
        check("press", 32'(o_press), 32'(ep));
        check("level", 32'(o_level), 32'(el));
        if (o_press[2]) p2_cnt++;
        if (o_press == 3'b111) p7_cnt++;
    endtask

    initial begin
        logic [2:0] cur;
        int         remain[3];
        bit         ren;

        rst = 1'b1; i_sw = 3'b111; i_rep_en = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b1, 3'b111, 1'b0);
        check("rst_out", 32'({o_press, o_level}), 32'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 3'b111, 1'b0);

        // Clean press on channel 0.
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 3'b110, 1'b0);
            if (k == 6) check("clean_pulse", 32'(o_press[0]), 32'd1);
            if (k == 5) check("clean_lvl_lo", 32'(o_level[0]), 32'd0);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 3'b111, 1'b0);
            if (k == 5) check("rel_lvl_hi", 32'(o_level[0]), 32'd1);
            if (k == 6) check("rel_lvl_lo", 32'(o_level[0]), 32'd0);
        end

        // Bounce on channel 1.
        for (int k = 0; k < 3; k++) step(1'b0, 3'b101, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 3'b111, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 3'b101, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, 3'b111, 1'b0);
        check("bounce_lvl", 32'(o_level[1]), 32'd0);

        // Auto-repeat with and without enable.
        for (int pass = 0; pass < 2; pass++) begin
            ren = (pass == 0);
            p2_cnt = 0;
            for (int k = 0; k < 45; k++) begin
                step(1'b0, 3'b011, ren);
                if (k == 6) check("rep_first", 32'(o_press[2]), 32'd1);
            end
            for (int k = 0; k < 12; k++) step(1'b0, 3'b111, ren);
            check("rep_count", 32'(p2_cnt), ren ? 32'd6 : 32'd1);
        end

        // Release glitch on channel 0.
        for (int k = 0; k < 10; k++) step(1'b0, 3'b110, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 3'b111, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 3'b110, 1'b0);
            check("glitch_lvl", 32'(o_level[0]), 32'd1);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 3'b111, 1'b0);

        // Reset during hold on channel 2.
        for (int k = 0; k < 30; k++) step(1'b0, 3'b011, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'b011, 1'b1);
            check("rst_hold", 32'({o_press, o_level}), 32'h0);
        end
        p2_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 3'b011, 1'b1);
            if (k == 6) check("rst_repress", 32'(o_press[2]), 32'd1);
        end
        check("rst_rep_count", 32'(p2_cnt), 32'd4);
        for (int k = 0; k < 10; k++) step(1'b0, 3'b111, 1'b0);

        // Simultaneous press.
        p7_cnt = 0;
        for (int k = 0; k < 10; k++) step(1'b0, 3'b000, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, 3'b111, 1'b0);
        check("all_three", 32'(p7_cnt), 32'd1);

        // Random runs per channel, occasional reset and enable changes.
        cur = 3'b111; ren = 1'b0;
        for (int i = 0; i < 3; i++) remain[i] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (remain[i] == 0) begin
                    cur[i] = $urandom_range(0, 1) == 1;
                    remain[i] = (i == 2 && !cur[i]) ? $urandom_range(1, 60) : $urandom_range(1, 12);
                end
                remain[i]--;
            end
            if ($urandom_range(0, 99) == 0) ren = ~ren;
            step($urandom_range(0, 299) == 0, cur, ren);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sw_cond.md
SW_COND -- requirements
Module: sw_cond

Interface
REQ-001 SHALL have parameter DEB_CNT, default 500000, debounce stability window in clk cycles (10 ms at 50 MHz); legal range is DEB_CNT >= 1.
REQ-002 SHALL have parameter HOLD_CNT, default 25000000, hold time in clk cycles before channel 2 auto-repeat starts (0.5 s).
REQ-003 SHALL have parameter REP_CNT, default 5000000, auto-repeat period in clk cycles (0.1 s); legal range is HOLD_CNT > REP_CNT >= 1.
REQ-004 SHALL have port: clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: i_sw  input  3  raw push-buttons, active-low, asynchronous to clk; [0]=mode, [1]=position, [2]=increment.
REQ-007 SHALL have port: i_rep_en  input  1  enables auto-repeat on channel 2 (tied to setup mode by the clock controller).
REQ-008 SHALL have port: o_press  output  3  one-clk-wide, active-high event pulse per channel.
REQ-009 SHALL have port: o_level  output  3  debounced pressed level per channel, active-high.
REQ-010 SHALL use one clock, clk, for all logic; reset is synchronous and active-high (rst).

Function
REQ-011 SHALL pass each i_sw bit through a 2-flop synchronizer; "pressed" means the synchronizer output is 0.
REQ-012 SHALL run one independent FSM per channel, with states IDLE, DB_P, PRESSED and DB_R, each with its own 32-bit debounce counter.
REQ-013 SHALL, in IDLE, move to DB_P with counter=0 when pressed.
REQ-014 SHALL, in DB_P, return to IDLE on release; otherwise increment the counter; when counter==DEB_CNT-1 and still pressed, go to PRESSED and set o_press[i]=1 for exactly the next cycle.
REQ-015 SHALL, in PRESSED, move to DB_R with counter=0 on release.
REQ-016 SHALL, in DB_R, return to PRESSED on press without emitting a pulse; otherwise increment the counter; at counter==DEB_CNT-1, go to IDLE.
REQ-017 SHALL drive o_level[i]=1 in PRESSED and DB_R, and 0 in IDLE and DB_P; o_level and o_press SHALL be registered outputs.
REQ-018 SHALL meet this latency: if i_sw[i] is first sampled low at edge 0 and held, state becomes PRESSED at edge DEB_CNT+2, and o_press[i] is high for the cycle following that edge.
REQ-019 SHALL give channel 2 a 32-bit repeat counter and a rep_phase flag, both cleared whenever the channel-2 state is not PRESSED or i_rep_en=0.
REQ-020 SHALL, while channel 2 is in PRESSED with i_rep_en=1, increment the repeat counter each cycle, with this behaviour:
  - rep_phase=0 and counter==HOLD_CNT-1: pulse o_press[2], clear the counter, set rep_phase=1.
  - rep_phase=1 and counter==REP_CNT-1: pulse o_press[2], clear the counter.
REQ-021 SHALL give repeat pulses the same one-cycle width as press pulses; channels 0 and 1 never auto-repeat.
REQ-022 SHALL keep channels fully independent; simultaneous pulses on several channels in the same cycle are legal and required.
REQ-023 SHALL drop any press shorter than DEB_CNT cycles (post-synchronizer) with no pulse, and mask any release glitch shorter than DEB_CNT cycles (no second pulse, o_level stays 1).
REQ-024 SHALL produce no pulse on release.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, set synchronizer flops to 1, all states to IDLE, all counters and rep_phase to 0, and o_press and o_level to 0.
REQ-026 SHALL, when rst is deasserted with a button held, treat the button as a new press: a full debounce followed by exactly one pulse, DEB_CNT+2 edges after the first non-reset edge.
REQ-027 SHALL abort any debounce or repeat in progress when rst is asserted mid-operation, with no pulse emitted.

Verification (DEB_CNT=4, HOLD_CNT=20, REP_CNT=5)
REQ-028 SHALL cover a clean press: i_sw[0] low from edge 0 for 30 cycles -> o_press[0] high only in cycle after edge 6; o_level[0]=1 from edge 6 until 4+2 edges after release.
REQ-029 SHALL cover a bounce: i_sw[1] low 3 cycles, high 2, low 3, then high -> no o_press[1] pulse; o_level[1] stays 0.
REQ-030 SHALL cover auto-repeat: i_rep_en=1, i_sw[2] held low 45 cycles from edge 0 -> o_press[2] pulses after edges 6, 26, 31, 36, 41, 46 and no others; the same stimulus with i_rep_en=0 -> only the edge-6 pulse.
REQ-031 SHALL cover a release glitch: channel 0 in PRESSED, i_sw[0] high 2 cycles then low again -> no extra pulse; o_level[0] never drops.
REQ-032 SHALL cover reset during hold: i_sw[2] held low, rst pulsed for 3 cycles mid-repeat -> outputs are 0 during reset; exactly one pulse 6 edges after rst deasserts, then repeats resume on HOLD_CNT/REP_CNT timing.
REQ-033 SHALL cover a simultaneous press: all i_sw low at edge 0 -> o_press=3'b111 in the single cycle after edge 6.
